// File: rtl/pio_handshake_arbiter.sv
// pio_handshake_arbiter
// Avalon-MM slave that arbitrates several requesters round-robin onto one
// Nios acknowledge channel. The granted requester's index and data word are
// latched for software, an interrupt is raised while the grant is pending,
// and a software ACK write starts a 4-phase req/ack handshake back to it.
//
// Handshake semantics (requester side, 4-phase level protocol):
//   requester raises req_i[k] and holds req_data_i[k] -> block grants and
//   latches -> software writes ACK -> block raises ack_o[k] -> requester drops
//   req_i[k] -> block drops ack_o[k] -> one dead cycle -> next arbitration.
//   A request withdrawn before the ACK still receives a one-cycle ack pulse.
//
// o_dbg_state exposes the FSM state encoding (0 IDLE, 1 PENDING, 2 ACK_HI,
// 3 ACK_LO) so checkers can observe it directly.

module pio_handshake_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [1:0]                  address,
   input  logic                        chipselect,
   input  logic                        write_n,
   input  logic [31:0]                 writedata,
   output logic [31:0]                 readdata,
   output logic                        irq,
   input  logic [NUM_REQ-1:0]          req_i,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
   output logic [NUM_REQ-1:0]          ack_o,
   output logic [1:0]                  o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_ACK_HI  = 2'd2,
      ST_ACK_LO  = 2'd3
   } state_t;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_ACK    = 2'd2;
   localparam logic [1:0] ADDR_CTRL   = 2'd3;

   // Registers
   state_t              r_state;
   logic                r_en;
   logic                r_irq_en;
   logic [NUM_REQ-1:0]  r_mask;
   logic [DATA_W-1:0]   r_data;
   logic [2:0]          r_index;
   logic [2:0]          r_rr_ptr;
   logic [NUM_REQ-1:0]  r_ack;
   logic                r_irq;

   // Combinational helpers
   logic                w_wr;
   logic                w_ack_wr;
   logic                w_ctrl_wr;
   logic [7:0]          w_req8;
   logic [7:0]          w_mask8;
   logic [7:0]          w_elig8;
   logic                w_found;
   logic [2:0]          w_grant_idx;
   logic [3:0]          w_cand;
   logic [DATA_W-1:0]   w_sel_data;
   logic [7:0]          w_ack_onehot8;
   logic [3:0]          w_index_inc;
   logic [2:0]          w_rr_next;
   logic                w_pending;
   logic                w_busy;
   logic [31:0]         w_data_ext;
   logic [31:0]         w_status;
   logic [31:0]         w_ctrl_rd;
   logic                w_unused;

   assign w_wr      = chipselect && !write_n;
   assign w_ack_wr  = w_wr && (address == ADDR_ACK) && writedata[0];
   assign w_ctrl_wr = w_wr && (address == ADDR_CTRL);

   // Pad per-requester vectors to 8 bits so a 3-bit index always fits.
   assign w_req8  = 8'(req_i);
   assign w_mask8 = 8'(r_mask);
   assign w_elig8 = w_req8 & ~w_mask8;

   // Round-robin search: first eligible requester at or after the rr pointer.
   always_comb begin
      w_found     = 1'b0;
      w_grant_idx = r_rr_ptr;
      w_cand      = 4'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_cand = {1'b0, r_rr_ptr} + 4'(i);
         if (w_cand >= 4'(NUM_REQ)) begin
            w_cand = w_cand - 4'(NUM_REQ);
         end
         if (!w_found && w_elig8[w_cand[2:0]]) begin
            w_found     = 1'b1;
            w_grant_idx = w_cand[2:0];
         end
      end
   end

   // Select the data word of the requester about to be granted.
   always_comb begin
      w_sel_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (w_grant_idx == 3'(k)) begin
            w_sel_data = req_data_i[k*DATA_W +: DATA_W];
         end
      end
   end

   assign w_ack_onehot8 = 8'd1 << r_index;

   // Next rr pointer is one past the granted index, wrapping; constant 0 when NUM_REQ=1.
   assign w_index_inc = {1'b0, r_index} + 4'd1;
   assign w_rr_next   = (w_index_inc >= 4'(NUM_REQ)) ? 3'd0 : w_index_inc[2:0];

   // Software-visible control register; arbitration always sees the pre-write value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_en     <= 1'b0;
         r_irq_en <= 1'b0;
         r_mask   <= '0;
      end else if (w_ctrl_wr) begin
         r_en     <= writedata[0];
         r_irq_en <= writedata[1];
         r_mask   <= writedata[8 +: NUM_REQ];
      end
   end

   // Arbitration and handshake sequencer with registered ack and irq.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_data   <= '0;
         r_index  <= 3'd0;
         r_rr_ptr <= 3'd0;
         r_ack    <= '0;
         r_irq    <= 1'b0;
      end else begin
         r_irq <= (r_state == ST_PENDING) && r_irq_en;
         case (r_state)
            ST_IDLE: begin
               r_ack <= '0;
               if (r_en && w_found) begin
                  r_index <= w_grant_idx;
                  r_data  <= w_sel_data;
                  r_state <= ST_PENDING;
               end
            end
            ST_PENDING: begin
               if (w_ack_wr) begin
                  r_ack   <= w_ack_onehot8[NUM_REQ-1:0];
                  r_state <= ST_ACK_HI;
               end
            end
            ST_ACK_HI: begin
               if (!w_req8[r_index]) begin
                  r_ack   <= '0;
                  r_state <= ST_ACK_LO;
               end
            end
            ST_ACK_LO: begin
               r_ack    <= '0;
               r_rr_ptr <= w_rr_next;
               r_state  <= ST_IDLE;
            end
            default: begin
               r_ack   <= '0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign w_pending  = (r_state == ST_PENDING);
   assign w_busy     = (r_state != ST_IDLE);
   assign w_data_ext = 32'(r_data);
   assign w_status   = {16'd0, w_req8, 1'b0, r_index, 2'b00, w_busy, w_pending};
   assign w_ctrl_rd  = {16'd0, w_mask8, 6'd0, r_irq_en, r_en};

   // Zero-wait-state read mux driven directly by the address.
   always_comb begin
      readdata = 32'd0;
      case (address)
         ADDR_DATA:   readdata = w_data_ext;
         ADDR_STATUS: readdata = w_status;
         ADDR_ACK:    readdata = 32'd0;
         ADDR_CTRL:   readdata = w_ctrl_rd;
         default:     readdata = 32'd0;
      endcase
   end

   // Only a few writedata bits are decoded; the rest are intentionally ignored.
   assign w_unused = ^writedata;

   assign ack_o       = r_ack;
   assign irq         = r_irq;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pio_handshake_arbiter.sv
// Directed bench for pio_handshake_arbiter (NUM_REQ=4, DATA_W=32).
module tb_pio_handshake_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;

  localparam logic [31:0] S_IDLE    = 32'd0;
  localparam logic [31:0] S_PENDING = 32'd1;
  localparam logic [31:0] S_ACK_HI  = 32'd2;
  localparam logic [31:0] S_ACK_LO  = 32'd3;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]                address = 2'd0;
  logic                      chipselect = 1'b0;
  logic                      write_n = 1'b1;
  logic [31:0]               writedata = 32'd0;
  logic [31:0]               readdata;
  logic                      irq;
  logic [NUM_REQ-1:0]        req_i = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data_i = '0;
  logic [NUM_REQ-1:0]        ack_o;
  logic [1:0]                dbg_state;

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] d [4];

  pio_handshake_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .irq         (irq),
    .req_i       (req_i),
    .req_data_i  (req_data_i),
    .ack_o       (ack_o),
    .o_dbg_state (dbg_state)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] data);
    address    = a;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  task automatic chk_state(input string tag, input logic [31:0] exp);
    check(tag, 32'(dbg_state), exp);
  endtask

  task automatic chk_ack(input string tag, input logic [31:0] exp);
    check(tag, 32'(ack_o), exp);
  endtask

  // One full round-robin handshake, starting in IDLE with all requests high.
  task automatic rr_step(input int step, input int exp_idx);
    tick();
    chk_state($sformatf("rr%0d_pending", step), S_PENDING);
    address = 2'd1;
    #1;
    check($sformatf("rr%0d_index", step), 32'(readdata[6:4]), 32'(exp_idx));
    rd(2'd0, d[exp_idx], $sformatf("rr%0d_data", step));
    wr(2'd2, 32'd1);
    chk_ack($sformatf("rr%0d_ack_hi", step), 32'd1 << exp_idx);
    req_i[exp_idx] = 1'b0;
    tick();
    chk_ack($sformatf("rr%0d_ack_lo", step), 32'd0);
    chk_state($sformatf("rr%0d_acklo_state", step), S_ACK_LO);
    req_i[exp_idx] = 1'b1;
    tick();
    chk_state($sformatf("rr%0d_dead_cycle", step), S_IDLE);
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    d[0] = 32'hA000_0000;
    d[1] = 32'hB111_1111;
    d[2] = 32'hC222_2222;
    d[3] = 32'hD333_3333;

    // reset state
    tick();
    tick();
    chk_ack("rst_ack", 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    chk_state("rst_state", S_IDLE);
    rd(2'd3, 32'd0, "rst_ctrl");
    rd(2'd0, 32'd0, "rst_data");
    reset_n = 1'b1;
    tick();

    // single request; disabled block must not grant
    req_data_i = {d[3], d[2], d[1], 32'hDEAD_BEEF};
    req_i = 4'b0001;
    tick();
    tick();
    chk_state("disabled_no_grant", S_IDLE);
    wr(2'd3, 32'h0000_0003);
    chk_state("ctrl_write_same_cycle", S_IDLE);
    tick();
    rd(2'd1, 32'h0000_0103, "single_status_pending");
    check("single_irq_lag", 32'(irq), 32'd0);
    tick();
    check("single_irq", 32'(irq), 32'd1);
    rd(2'd0, 32'hDEAD_BEEF, "single_data");
    rd(2'd2, 32'd0, "ack_reg_reads_zero");
    wr(2'd2, 32'd1);
    chk_ack("single_ack_hi", 32'd1);
    rd(2'd1, 32'h0000_0102, "single_status_ackhi");
    tick();
    chk_ack("single_ack_hold", 32'd1);
    check("single_irq_drop", 32'(irq), 32'd0);
    req_i = 4'b0000;
    tick();
    chk_ack("single_ack_lo", 32'd0);
    chk_state("single_acklo", S_ACK_LO);
    tick();
    rd(2'd1, 32'd0, "single_status_idle");

    // round-robin: rr pointer is 1 after the single-request handshake
    req_data_i = {d[3], d[2], d[1], d[0]};
    req_i = 4'b1111;
    rr_step(0, 1);
    rr_step(1, 2);
    rr_step(2, 3);
    rr_step(3, 0);
    rr_step(4, 1);
    req_i = 4'b0000;

    // mask and enable (rr pointer now 2)
    wr(2'd3, 32'h0000_0503);
    req_i = 4'b0101;
    tick();
    tick();
    tick();
    chk_state("masked_no_grant", S_IDLE);
    rd(2'd3, 32'h0000_0503, "ctrl_readback");
    wr(2'd3, 32'h0000_0003);
    chk_state("unmask_uses_old_ctrl", S_IDLE);
    tick();
    chk_state("unmask_grant", S_PENDING);
    address = 2'd1;
    #1;
    check("unmask_index", 32'(readdata[6:4]), 32'd2);
    wr(2'd2, 32'd1);
    chk_ack("mask_ack_hi", 32'b0100);
    wr(2'd3, 32'h0000_0002);
    chk_ack("disable_inflight_hold", 32'b0100);
    req_i = 4'b0001;
    tick();
    chk_ack("disable_inflight_lo", 32'd0);
    tick();
    chk_state("disable_back_idle", S_IDLE);
    tick();
    tick();
    chk_state("disabled_no_new_grant", S_IDLE);
    chk_ack("disabled_ack_quiet", 32'd0);

    // spurious ACK in IDLE
    wr(2'd2, 32'd1);
    chk_ack("spurious_ack", 32'd0);
    chk_state("spurious_state", S_IDLE);
    tick();
    chk_ack("spurious_ack_later", 32'd0);

    // grant req0 (rr pointer 3), then freeze data and withdraw the request
    wr(2'd3, 32'h0000_0003);
    tick();
    chk_state("freeze_grant", S_PENDING);
    rd(2'd0, d[0], "freeze_data_latched");
    req_data_i = {NUM_REQ{32'h5555_AAAA}};
    req_i = 4'b0000;
    tick();
    tick();
    rd(2'd0, d[0], "freeze_data_held");
    rd(2'd1, 32'h0000_0003, "withdraw_status");
    check("withdraw_irq", 32'(irq), 32'd1);
    wr(2'd2, 32'd1);
    chk_ack("withdraw_pulse_hi", 32'd1);
    tick();
    chk_ack("withdraw_pulse_lo", 32'd0);
    chk_state("withdraw_acklo", S_ACK_LO);
    tick();
    chk_state("withdraw_idle", S_IDLE);

    // reset in the middle of a handshake (rr pointer 1, only req0 eligible)
    req_data_i = {d[3], d[2], d[1], d[0]};
    req_i = 4'b0001;
    tick();
    chk_state("rstmid_grant", S_PENDING);
    wr(2'd2, 32'd1);
    chk_ack("rstmid_ack_hi", 32'd1);
    tick();
    #1;
    reset_n = 1'b0;
    #1;
    chk_ack("rstmid_ack_drop", 32'd0);
    check("rstmid_irq", 32'(irq), 32'd0);
    rd(2'd3, 32'd0, "rstmid_ctrl");
    chk_state("rstmid_state", S_IDLE);
    #1;
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    chk_state("after_rst_no_grant", S_IDLE);
    wr(2'd3, 32'h0000_0001);
    chk_state("after_rst_enable_edge", S_IDLE);
    tick();
    chk_state("after_rst_grant", S_PENDING);
    rd(2'd0, d[0], "after_rst_data");

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
